slice_alu: RTL

Digit-serial ALU for the multicycle MIPS datapath. It consumes the 3-bit AluCtl code produced by the ALU control decoder and operates on two latched WIDTH-bit operands, SLICE bits per clock. It returns a registered result, which plays the role of ALUOut, plus Zero, Ovf and Err flags. Both sides use a valid/ready handshake, so the multicycle controller can stall on the result.

---
 rtl/slice_alu.sv | 136 +++++++++++++
 1 files changed

// File: rtl/slice_alu.sv
// slice_alu: digit-serial MIPS ALU, SLICE bits per clock.
// Valid/ready on both sides; registered AluOut/Zero/Ovf/Err.
module slice_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       AluCtl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] AluOut,
  output logic             Zero,
  output logic             Ovf,
  output logic             Err
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, acc, acc_nx, res_nx;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry, last, inv, legal;
  logic             c_msb, v, ovf_nx;
  logic [SLICE-1:0] a_s, b_s, s_res;
  logic [SLICE:0]   sum;

  always_comb begin
    inv   = (op_q == OP_SUB) || (op_q == OP_SLT);
    a_s   = a_q[SLICE-1:0];
    b_s   = inv ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
    sum   = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry};
    // carry into the slice MSB recovered from the sum bit
    c_msb = sum[SLICE-1] ^ a_s[SLICE-1] ^ b_s[SLICE-1];
    v     = c_msb ^ sum[SLICE];
    case (op_q)
      OP_AND:  s_res = a_s & b_s;
      OP_OR:   s_res = a_s | b_s;
      default: s_res = sum[SLICE-1:0];
    endcase
    acc_nx = acc;
    acc_nx[int'(cnt)*SLICE +: SLICE] = s_res;
    last  = (cnt == CW'(N-1));
    legal = (op_q == OP_ADD) || (op_q == OP_SUB) ||
            (op_q == OP_AND) || (op_q == OP_OR) ||
            (op_q == OP_SLT);
    res_nx = acc_nx;
    ovf_nx = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: ovf_nx = v;
      OP_SLT: res_nx = {{(WIDTH-1){1'b0}}, sum[SLICE-1] ^ v};
      OP_AND, OP_OR: ;
      default: res_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (InValid) state_nx = RUN;
      RUN:  if (last)    state_nx = DONE;
      DONE: if (OutReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    InReady  = (state == IDLE);
    OutValid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      AluOut <= '0;
      Zero   <= 1'b1;
      Ovf    <= 1'b0;
      Err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (InValid) begin
          a_q   <= SrcA;
          b_q   <= SrcB;
          op_q  <= AluCtl;
          acc   <= '0;
          cnt   <= '0;
          carry <= (AluCtl == OP_SUB) || (AluCtl == OP_SLT);
        end
        RUN: begin
          a_q   <= a_q >> SLICE;
          b_q   <= b_q >> SLICE;
          cnt   <= cnt + 1'b1;
          carry <= sum[SLICE];
          acc   <= acc_nx;
          if (last) begin
            AluOut <= res_nx;
            Zero   <= (res_nx == '0);
            Ovf    <= ovf_nx & legal;
            Err    <= ~legal;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
